// File: rtl/instr_loader_if.sv
// Descriptor handshake and instruction-memory write bus between a boot/bench
// source (master) and instr_loader (slave).
interface instr_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [5:0]  in_funct;
    logic [25:0] in_imm;
    logic        in_last;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_loader.sv
// Encodes MIPS instruction descriptors and writes them to consecutive words of
// instruction memory. Optional XOR checksum output enabled by LOADER_CHECKSUM_EN.
module instr_loader #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    instr_loader_if.slave          bus,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err,
    output logic [31:0]            o_checksum
);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_count;
    logic          r_last;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    logic [31:0]   w_word;
    logic          w_illegal;
    logic [31:0]   w_addr;
    logic [CW-1:0] w_count_inc;
    logic          w_full;
    logic          w_start_ok;

    always_comb begin
        w_word = 32'h0;
        case (bus.in_kind)
            3'd0:    w_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct};
            3'd1:    w_word = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            3'd2:    w_word = {6'h0d, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            3'd3:    w_word = {6'h0c, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            3'd4:    w_word = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            3'd5:    w_word = {6'h05, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            3'd6:    w_word = {6'h02, bus.in_imm};
            default: w_word = 32'h0;
        endcase
    end

    assign w_illegal   = (bus.in_kind == 3'd7);
    // Byte address wraps naturally at 2^32.
    assign w_addr      = BASE_ADDR + (32'(r_count) << 2);
    assign w_count_inc = r_count + 1'b1;
    assign w_full      = (w_count_inc == CW'(DEPTH));
    assign w_start_ok  = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_last  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_state <= S_LOAD;
                        r_count <= '0;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        if (w_illegal) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            // The strobe is registered here so it is high during WRITE.
                            r_state <= S_WRITE;
                            r_we    <= 1'b1;
                            r_addr  <= w_addr;
                            r_wdata <= w_word;
                            r_last  <= bus.in_last;
                        end
                    end
                end
                S_WRITE: begin
                    r_count <= w_count_inc;
                    if (r_last || w_full) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        if (!r_last) begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_state <= S_LOAD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= 32'h0;
        end else if (w_start_ok) begin
            r_checksum <= 32'h0;
        end else if (r_we) begin
            r_checksum <= r_checksum ^ r_wdata;
        end
    end

    assign o_checksum = r_checksum;
`else
    assign o_checksum = 32'h0;
`endif

    assign bus.in_ready  = (r_state == S_LOAD);
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign o_count       = r_count;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err         = r_err;
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader (DEPTH=4): a transaction-level model predicts
// every memory write; a negedge monitor checks each write against it.
module tb_instr_loader;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam logic [5:0]  IOP [1:5] = '{6'h08, 6'h0d, 6'h0c, 6'h04, 6'h05};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  count;
    logic        busy, done, err;
    logic [31:0] checksum;

    instr_loader_if bus();

    instr_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .bus(bus),
        .o_count(count), .o_busy(busy), .o_done(done), .o_err(err), .o_checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;

    int          tests = 0;
    int          fails = 0;
    wr_t         exp_q[$];
    logic [31:0] cap_q[$];
    int          n_writes = 0;
    int          w0 = 0;
    int          c0 = 0;
    int          m_idx = 0;
    logic [31:0] m_sum = 32'h0;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] last_data = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    // Encoding taken directly from the instruction format rules.
    function automatic logic [31:0] enc(input logic [2:0] kind, input logic [4:0] rs, rt, rd, sh,
                                        input logic [5:0] fn, input logic [25:0] imm);
        if (kind == 3'd0) return {6'h00, rs, rt, rd, sh, fn};
        if (kind == 3'd6) return {6'h02, imm};
        if (kind == 3'd7) return 32'h0;
        return {IOP[int'(kind)], rs, rt, imm[15:0]};
    endfunction

    // Monitor: every write strobe must match the next predicted write.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (rst_n && bus.mem_we) begin
            n_writes++;
            last_addr = bus.mem_addr;
            last_data = bus.mem_wdata;
            cap_q.push_back(bus.mem_wdata);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", bus.mem_addr, e.addr);
                check("wr_data", bus.mem_wdata, e.data);
            end
            check("ready_low_in_write", {31'b0, bus.in_ready}, 32'h0);
        end
    end

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        m_idx = 0;
        m_sum = 32'h0;
        w0 = n_writes;
        c0 = cap_q.size();
        check("start_busy", {31'b0, busy}, 32'h1);
        check("start_ready", {31'b0, bus.in_ready}, 32'h1);
        check("start_done_clr", {31'b0, done}, 32'h0);
        check("start_err_clr", {31'b0, err}, 32'h0);
        check("start_count_clr", {29'b0, count}, 32'h0);
    endtask

    task automatic predict(input logic [31:0] word);
        wr_t w;
        w.addr = BASE + 32'(m_idx * 4);
        w.data = word;
        exp_q.push_back(w);
        m_idx++;
        m_sum ^= word;
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic send(input logic [2:0] kind, input logic [4:0] rs, rt, rd, sh,
                        input logic [5:0] fn, input logic [25:0] imm, input logic last,
                        input int bound, output bit acc);
        bus.in_kind = kind; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
        bus.in_shamt = sh; bus.in_funct = fn; bus.in_imm = imm; bus.in_last = last;
        bus.in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (bus.in_ready) begin
                if (kind != 3'd7) predict(enc(kind, rs, rt, rd, sh, fn, imm));
                @(posedge clk);
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (acc) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_imm = 26'h3ff_ffff;
            bus.in_rs = 5'h1f;
            if (kind != 3'd7) check("we_after_accept", {31'b0, bus.mem_we}, 32'h1);
        end else begin
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) check("done_timeout", 32'h0, 32'h1);
    endtask

    task automatic check_cksum(input logic [31:0] lit);
`ifdef LOADER_CHECKSUM_EN
        check("checksum_model", checksum, m_sum);
        check("checksum_lit", checksum, lit);
`else
        check("checksum_tied", checksum, lit & 32'h0);
`endif
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit acc;
        bus.in_valid = 1'b0; bus.in_kind = 3'd0; bus.in_rs = 5'd0; bus.in_rt = 5'd0;
        bus.in_rd = 5'd0; bus.in_shamt = 5'd0; bus.in_funct = 6'd0; bus.in_imm = 26'd0;
        bus.in_last = 1'b0;

        // Reset values
        #12;
        check("rst_ready", {31'b0, bus.in_ready}, 32'h0);
        check("rst_we", {31'b0, bus.mem_we}, 32'h0);
        check("rst_addr", bus.mem_addr, 32'h0);
        check("rst_wdata", bus.mem_wdata, 32'h0);
        check("rst_count", {29'b0, count}, 32'h0);
        check("rst_busy_done_err", {29'b0, busy, done, err}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_ready", {31'b0, bus.in_ready}, 32'h0);

        // Single ADDI
        do_start();
        send(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 26'd5, 1'b1, 20, acc);
        check("addi_acc", {31'b0, acc}, 32'h1);
        wait_done(10);
        check("addi_addr", last_addr, 32'h0040_0000);
        check("addi_data", last_data, 32'h2008_0005);
        check("addi_done_err", {30'b0, done, err}, 32'h2);
        check("addi_count", {29'b0, count}, 32'h1);
        check("addi_writes", 32'(n_writes - w0), 32'h1);
        check_cksum(32'h2008_0005);

        // R-type, BNE, J
        do_start();
        send(3'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 26'd0, 1'b0, 20, acc);
        @(negedge clk);
        check("ready_back_n2", {31'b0, bus.in_ready}, 32'h1);
        send(3'd5, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 26'h000_FFFE, 1'b0, 20, acc);
        send(3'd6, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 26'h010_0008, 1'b1, 20, acc);
        wait_done(10);
        check("seq_w0", cap_q[c0], 32'h0109_5020);
        check("seq_w1", cap_q[c0 + 1], 32'h1509_FFFE);
        check("seq_w2", cap_q[c0 + 2], 32'h0810_0008);
        check("seq_last_addr", last_addr, 32'h0040_0008);
        check("seq_count", {29'b0, count}, 32'h3);
        check("seq_err", {31'b0, err}, 32'h0);
        check_cksum(32'h1C10_AFD6);

        // Overflow: five descriptors without last, DEPTH=4
        do_start();
        for (int k = 0; k < 4; k++) begin
            send(3'd2, 5'(k), 5'(k + 1), 5'd0, 5'd0, 6'd0, 26'(16'h0100 + k), 1'b0, 20, acc);
            check("ovf_acc", {31'b0, acc}, 32'h1);
        end
        send(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 26'h0000_00ff, 1'b0, 6, acc);
        check("ovf_fifth_rejected", {31'b0, acc}, 32'h0);
        wait_done(10);
        check("ovf_done_err", {30'b0, done, err}, 32'h3);
        check("ovf_count", {29'b0, count}, 32'h4);
        check("ovf_writes", 32'(n_writes - w0), 32'h4);
        check("ovf_last_addr", last_addr, 32'h0040_000C);
        check("ovf_pending", 32'(exp_q.size()), 32'h0);

        // Illegal kind
        do_start();
        send(3'd7, 5'd1, 5'd2, 5'd3, 5'd0, 6'd0, 26'd0, 1'b0, 20, acc);
        check("ill_acc", {31'b0, acc}, 32'h1);
        check("ill_done_err", {30'b0, done, err}, 32'h3);
        check("ill_we", {31'b0, bus.mem_we}, 32'h0);
        check("ill_writes", 32'(n_writes - w0), 32'h0);
        do_start();

        // Reset during the second WRITE cycle
        send(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 26'd7, 1'b0, 20, acc);
        send(3'd1, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 26'd9, 1'b0, 20, acc);
        check("prerst_count", {29'b0, count}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_we", {31'b0, bus.mem_we}, 32'h0);
        check("rst_mid_busy", {31'b0, busy}, 32'h0);
        check("rst_mid_count", {29'b0, count}, 32'h0);
        exp_q.delete();
        w0 = n_writes;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_ready", {31'b0, bus.in_ready}, 32'h0);
        end
        check("post_rst_writes", 32'(n_writes - w0), 32'h0);

        // in_valid held in IDLE, then start
        bus.in_kind = 3'd1; bus.in_rs = 5'd3; bus.in_rt = 5'd4; bus.in_imm = 26'h1234;
        bus.in_last = 1'b1; bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_hold_ready", {31'b0, bus.in_ready}, 32'h0);
        end
        check("idle_hold_writes", 32'(n_writes - w0), 32'h0);
        do_start();
        predict(enc(3'd1, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 26'h1234));
        @(posedge clk);
        @(negedge clk) bus.in_valid = 1'b0;
        check("held_we", {31'b0, bus.mem_we}, 32'h1);
        check("held_data", bus.mem_wdata, 32'h2064_1234);
        wait_done(10);
        check("held_count", {29'b0, count}, 32'h1);
        check("held_writes", 32'(n_writes - w0), 32'h1);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
